clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
Core-local interruptor. It owns the machine timer (mtime/mtimecmp) and the machine software-interrupt bit (msip), and it drives the level interrupt lines into the CSR unit's mip.MTIP/MSIP inputs. It is a memory-mapped responder on the core's uncached data-bus port and supports one outstanding transaction. It is the source end of the time_interrupt line that the CSR block consumes.

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, base of the 64 KiB CLINT window
TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  responder can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  64  byte address
req_wdata  in  64  write data
req_wstrb  in  8  write byte enables
resp_valid  out  1  response valid
resp_ready  in  1  initiator accepts the response
resp_rdata  out  64  read data; 0 for writes and errors
resp_err  out  1  access fault
time_interrupt  out  1  MTIP level to the CSR unit
soft_interrupt  out  1  MSIP level to the CSR unit
mtime_o  out  64  current mtime, for the time CSR/difftest

Behaviour:
- Register map (offset from BASE_ADDR, 8-byte aligned):
  - 0x0000: msip. Only bit 0 is implemented; bits 63:1 read 0 and ignore writes.
  - 0x4000: mtimecmp.
  - 0xBFF8: mtime.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, FSM=IDLE.
- Output reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, time_interrupt=0, soft_interrupt=0.
- Reset mid-transaction drops resp_valid in the next cycle. The pending response is discarded.
- Handshake FSM has two states, IDLE and RESP:
  - IDLE: req_ready=1. On req_valid&req_ready, decode and perform the access in the same cycle, then go to RESP.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1, then return to IDLE.
  - Minimum turnaround is 2 cycles per transaction. A new request is not accepted in the cycle resp_ready is sampled.
- Reads: data is captured at the accept edge, so a read of mtime returns the value before that edge's tick.
- Writes: byte-merged per req_wstrb. Bytes with strobe=0 are kept. wstrb=0 is a legal no-op with resp_err=0.
- Error cases: address outside the three registers, or req_addr[2:0]!=0, gives resp_err=1, rdata=0, and no state change.
- Prescaler: counts 0..TICK_DIV-1. mtime increments when prescaler==TICK_DIV-1, and the prescaler then returns to 0. With TICK_DIV=1, mtime increments every cycle.
- mtime wraps from 2^64-1 to 0 with no flag.
- Write to mtime in the same cycle as a tick: the written bytes win and unwritten bytes take the ticked value. The prescaler is unaffected.
- time_interrupt is registered: time_interrupt <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - It asserts one cycle after mtime reaches mtimecmp.
  - It deasserts one cycle after a mtimecmp write makes the compare false.
- soft_interrupt is registered from msip[0], one cycle after the write edge.
- Both interrupt outputs are pure levels. There is no ack input; software clears them by writing mtimecmp or msip.
- mtime_o = the mtime register, combinational from the flop.

Test Plan:
1. Reset, then idle 10 cycles with TICK_DIV=1 -> mtime_o=10, time_interrupt=0. A read of 0x0200_BFF8 returns the value at its accept edge, resp_err=0.
2. Write mtimecmp=20 with wstrb=FF at mtime=5 -> time_interrupt=0 until the cycle after mtime_o=20, then 1. Write mtimecmp=FFFF_FFFF_FFFF_FFFF -> time_interrupt=0 one cycle after the register update.
3. TICK_DIV=4, run from reset 16 cycles -> mtime_o=4. Write mtime=0xFFFF_FFFF_FFFF_FFFF -> wraps to 0 after 4 cycles.
4. Write mtime with wdata=0x1122_3344_5566_7788, wstrb=0x0F, old mtime=0xAAAA_AAAA_0000_0000 -> mtime=0xAAAA_AAAA_5566_7788, with no tick added in the write cycle. Then write msip=0xFFFF_FFFF_FFFF_FFFF -> soft_interrupt=1, and a read of msip returns 1.
5. Read 0x0200_1000 and read 0x0200_4004 -> both give resp_err=1, rdata=0; a mtimecmp read-back shows no state change.
6. Hold resp_ready=0 for 5 cycles after a read -> resp_valid and resp_rdata stay stable and req_ready=0. Assert rst while in RESP -> resp_valid=0 and req_ready=1 next cycle.

Source files
------------

// File: rtl/clint_bus_if.sv
// ============================================================================
// Module      : clint_bus_if
// Description : Single-outstanding request/response bus between the core's
//               uncached data port and the CLINT responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clint_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  // Initiator side (core data port)
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Responder side (CLINT)
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/clint_timer.sv
// ============================================================================
// Module      : clint_timer
// Description : Core-local interruptor: mtime/mtimecmp machine timer, msip
//               software-interrupt bit, level MTIP/MSIP outputs and a
//               memory-mapped register window on the uncached data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  clint_bus_if.slave       bus,
  output logic             time_interrupt,
  output logic             soft_interrupt,
  output logic [63:0]      mtime_o
);

  localparam logic [0:0]  c_st_idle   = 1'b0;
  localparam logic [0:0]  c_st_resp   = 1'b1;
  localparam logic [15:0] c_off_msip  = 16'h0000;
  localparam logic [15:0] c_off_cmp   = 16'h4000;
  localparam logic [15:0] c_off_mtime = 16'hBFF8;
  localparam logic [15:0] c_div_max   = 16'(TICK_DIV - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [15:0] r_presc;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        r_tirq;
  logic        r_sirq;

  logic        w_accept;
  logic        w_in_window;
  logic        w_misaligned;
  logic        w_hit_msip;
  logic        w_hit_cmp;
  logic        w_hit_mtime;
  logic        w_err;
  logic        w_wr;
  logic        w_tick;
  logic [15:0] w_presc_next;
  logic [63:0] w_mtime_ticked;
  logic [63:0] w_mtime_next;
  logic [63:0] w_cmp_next;
  logic        w_msip_next;
  logic [63:0] w_rdata;

  // Byte-lane merge: lanes with a strobe take new data, others keep old.
  function automatic logic [63:0] f_merge(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_next;
  end

  // Next-state: accept in IDLE, hold RESP until the initiator takes it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (bus.req_valid) w_state_next = c_st_resp;
      c_st_resp: if (bus.resp_ready) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // Handshake outputs decoded from state; response payload held in flops.
  always_comb begin
    bus.req_ready  = (r_state == c_st_idle);
    bus.resp_valid = (r_state == c_st_resp);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  // Address decode, register next-values and read-data mux.
  always_comb begin
    w_accept     = bus.req_valid && (r_state == c_st_idle);
    w_in_window  = (bus.req_addr[63:16] == BASE_ADDR[63:16]);
    w_misaligned = (bus.req_addr[2:0] != 3'b000);
    w_hit_msip   = w_in_window && (bus.req_addr[15:0] == c_off_msip);
    w_hit_cmp    = w_in_window && (bus.req_addr[15:0] == c_off_cmp);
    w_hit_mtime  = w_in_window && (bus.req_addr[15:0] == c_off_mtime);
    w_err        = w_misaligned || !(w_hit_msip || w_hit_cmp || w_hit_mtime);
    w_wr         = w_accept && bus.req_we && !w_err;

    // The prescaler free-runs regardless of mtime writes.
    w_tick         = (r_presc == c_div_max);
    w_presc_next   = w_tick ? 16'd0 : r_presc + 16'd1;
    w_mtime_ticked = w_tick ? r_mtime + 64'd1 : r_mtime;

    // Written bytes override the ticked value; unwritten bytes keep the tick.
    w_mtime_next = w_mtime_ticked;
    if (w_wr && w_hit_mtime)
      w_mtime_next = f_merge(w_mtime_ticked, bus.req_wdata, bus.req_wstrb);

    w_cmp_next = r_mtimecmp;
    if (w_wr && w_hit_cmp)
      w_cmp_next = f_merge(r_mtimecmp, bus.req_wdata, bus.req_wstrb);

    w_msip_next = r_msip;
    if (w_wr && w_hit_msip && bus.req_wstrb[0])
      w_msip_next = bus.req_wdata[0];

    // Reads see pre-edge register values; writes and faults return zero.
    w_rdata = 64'd0;
    if (!bus.req_we && !w_err) begin
      if (w_hit_msip)       w_rdata = {63'd0, r_msip};
      else if (w_hit_cmp)   w_rdata = r_mtimecmp;
      else if (w_hit_mtime) w_rdata = r_mtime;
    end
  end

  // Timer, msip, response capture and registered interrupt levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_presc    <= 16'd0;
      r_rdata    <= 64'd0;
      r_err      <= 1'b0;
      r_tirq     <= 1'b0;
      r_sirq     <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_cmp_next;
      r_msip     <= w_msip_next;
      r_presc    <= w_presc_next;
      if (w_accept) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
      r_tirq     <= (r_mtime >= r_mtimecmp);
      r_sirq     <= r_msip;
    end
  end

  // Interrupt levels and the live mtime tap.
  always_comb begin
    time_interrupt = r_tirq;
    soft_interrupt = r_sirq;
    mtime_o        = r_mtime;
  end

endmodule

`default_nettype wire

// File: tb/tb_clint_timer.sv
// ============================================================================
// Module      : tb_clint_timer
// Description : Directed self-checking bench for clint_timer; one instance
//               ticks every cycle, a second ticks every fourth cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;  // 0: TICK_DIV=1 instance, 1: TICK_DIV=4 instance
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wstrb = 8'd0;
  logic        resp_ready = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;

  clint_bus_if bus1 ();
  clint_bus_if bus4 ();

  logic        ti1, si1, ti4, si4;
  logic [63:0] mt1, mt4;

  assign bus1.req_valid  = req_valid && !sel;
  assign bus1.req_we     = req_we;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus1.req_wstrb  = req_wstrb;
  assign bus1.resp_ready = resp_ready;
  assign bus4.req_valid  = req_valid && sel;
  assign bus4.req_we     = req_we;
  assign bus4.req_addr   = req_addr;
  assign bus4.req_wdata  = req_wdata;
  assign bus4.req_wstrb  = req_wstrb;
  assign bus4.resp_ready = resp_ready;

  clint_timer #(.BASE_ADDR(64'h0000_0000_0200_0000), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .time_interrupt(ti1), .soft_interrupt(si1), .mtime_o(mt1)
  );

  clint_timer #(.BASE_ADDR(64'h0000_0000_0200_0000), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .time_interrupt(ti4), .soft_interrupt(si4), .mtime_o(mt4)
  );

  wire        o_req_ready  = sel ? bus4.req_ready  : bus1.req_ready;
  wire        o_resp_valid = sel ? bus4.resp_valid : bus1.resp_valid;
  wire [63:0] o_resp_rdata = sel ? bus4.resp_rdata : bus1.resp_rdata;
  wire        o_resp_err   = sel ? bus4.resp_err   : bus1.resp_err;
  wire        o_tirq       = sel ? ti4 : ti1;
  wire        o_sirq       = sel ? si4 : si1;
  wire [63:0] o_mtime      = sel ? mt4 : mt1;

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // One transaction; entered and left at 1 time unit after a rising edge.
  task automatic bus_txn(input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] strb,
                         output logic [63:0] rdata, output logic err,
                         output logic [63:0] mt_after);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_wstrb = strb; resp_ready = 1'b1;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    mt_after = o_mtime;
    n = 0;
    while (o_resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL txn_timeout: got resp_valid=%b required 1", o_resp_valid);
    end
    rdata = o_resp_rdata;
    err   = o_resp_err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", o_req_ready); end
    n_cmp++; if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", o_resp_valid); end
    n_cmp++; if (o_resp_rdata !== 64'd0 || o_resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %h/%b required 0/0", o_resp_rdata, o_resp_err); end
    n_cmp++; if (o_tirq !== 1'b0 || o_sirq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b%b required 00", o_tirq, o_sirq); end
    n_cmp++; if (o_mtime !== 64'd0) begin n_fail++; $display("FAIL rst_mtime: got %h required 0", o_mtime); end
  endtask

  task automatic test_mtime_read();
    logic [63:0] rd, ma; logic er;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (o_mtime !== 64'd10) begin n_fail++; $display("FAIL idle10_mtime: got %0d required 10", o_mtime); end
    n_cmp++; if (o_tirq !== 1'b0) begin n_fail++; $display("FAIL idle10_tirq: got %b required 0", o_tirq); end
    bus_txn(1'b0, 64'h0200_BFF8, 64'd0, 8'h00, rd, er, ma);
    n_cmp++; if (rd !== 64'd10 || er !== 1'b0) begin n_fail++; $display("FAIL mtime_read: got %0d/%b required 10/0", rd, er); end
    n_cmp++; if (ma !== 64'd11) begin n_fail++; $display("FAIL mtime_after_accept: got %0d required 11", ma); end
  endtask

  task automatic test_timer_irq();
    logic [63:0] rd, ma; logic er; int n;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    bus_txn(1'b1, 64'h0200_4000, 64'd20, 8'hFF, rd, er, ma);
    n_cmp++; if (er !== 1'b0 || rd !== 64'd0) begin n_fail++; $display("FAIL cmp_write_resp: got %h/%b required 0/0", rd, er); end
    n = 0;
    while (o_mtime !== 64'd20 && n < 40) begin
      n_cmp++; if (o_tirq !== 1'b0) begin n_fail++; $display("FAIL tirq_early: got 1 at mtime %0d required 0", o_mtime); end
      @(posedge clk); #1; n++;
    end
    n_cmp++; if (o_tirq !== 1'b0) begin n_fail++; $display("FAIL tirq_at_20: got %b mtime %0d required 0 mtime 20", o_tirq, o_mtime); end
    @(posedge clk); #1;
    n_cmp++; if (o_tirq !== 1'b1) begin n_fail++; $display("FAIL tirq_after_20: got %b required 1", o_tirq); end
    bus_txn(1'b1, 64'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, ma);
    n_cmp++; if (o_tirq !== 1'b0) begin n_fail++; $display("FAIL tirq_cleared: got %b required 0", o_tirq); end
  endtask

  task automatic test_write_merge_msip();
    logic [63:0] rd, ma; logic er;
    bus_txn(1'b1, 64'h0200_BFF8, 64'hAAAA_AAAA_0000_0000, 8'hFF, rd, er, ma);
    n_cmp++; if (ma !== 64'hAAAA_AAAA_0000_0000) begin n_fail++; $display("FAIL mtime_full_write: got %h required aaaaaaaa00000000", ma); end
    bus_txn(1'b1, 64'h0200_BFF8, 64'h1122_3344_5566_7788, 8'h0F, rd, er, ma);
    n_cmp++; if (ma !== 64'hAAAA_AAAA_5566_7788) begin n_fail++; $display("FAIL mtime_merge: got %h required aaaaaaaa55667788", ma); end
    n_cmp++; if (o_mtime !== 64'hAAAA_AAAA_5566_7789) begin n_fail++; $display("FAIL mtime_merge_next: got %h required aaaaaaaa55667789", o_mtime); end
    n_cmp++; if (o_sirq !== 1'b0) begin n_fail++; $display("FAIL sirq_before: got %b required 0", o_sirq); end
    bus_txn(1'b1, 64'h0200_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, ma);
    n_cmp++; if (o_sirq !== 1'b1) begin n_fail++; $display("FAIL sirq_set: got %b required 1", o_sirq); end
    bus_txn(1'b0, 64'h0200_0000, 64'd0, 8'h00, rd, er, ma);
    n_cmp++; if (rd !== 64'd1 || er !== 1'b0) begin n_fail++; $display("FAIL msip_read: got %h/%b required 1/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [63:0] rd, ma; logic er;
    bus_txn(1'b1, 64'h0200_4000, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, ma);
    bus_txn(1'b0, 64'h0200_1000, 64'd0, 8'h00, rd, er, ma);
    n_cmp++; if (rd !== 64'd0 || er !== 1'b1) begin n_fail++; $display("FAIL err_unmapped: got %h/%b required 0/1", rd, er); end
    bus_txn(1'b0, 64'h0200_4004, 64'd0, 8'h00, rd, er, ma);
    n_cmp++; if (rd !== 64'd0 || er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned: got %h/%b required 0/1", rd, er); end
    bus_txn(1'b1, 64'h0200_4004, 64'd0, 8'hFF, rd, er, ma);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_wr: got %b required 1", er); end
    bus_txn(1'b1, 64'h0300_4000, 64'd0, 8'hFF, rd, er, ma);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_outside: got %b required 1", er); end
    bus_txn(1'b1, 64'h0200_4000, 64'd0, 8'h00, rd, er, ma);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wstrb0_err: got %b required 0", er); end
    bus_txn(1'b0, 64'h0200_4000, 64'd0, 8'h00, rd, er, ma);
    n_cmp++; if (rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0) begin n_fail++; $display("FAIL cmp_unchanged: got %h/%b required 0123456789abcdef/0", rd, er); end
  endtask

  task automatic test_resp_hold();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h0200_4000;
    req_wstrb = 8'h00; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (o_resp_valid !== 1'b1 || o_req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_hs[%0d]: got valid=%b ready=%b required 1/0", i, o_resp_valid, o_req_ready); end
      n_cmp++; if (o_resp_rdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL hold_rdata[%0d]: got %h required 0123456789abcdef", i, o_resp_rdata); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_resp: got valid=%b ready=%b required 0/1", o_resp_valid, o_req_ready); end
    resp_ready = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_prescaler_wrap();
    logic [63:0] rd, ma; logic er;
    sel = 1'b1;
    do_reset();
    repeat (16) @(posedge clk);
    #1;
    n_cmp++; if (o_mtime !== 64'd4) begin n_fail++; $display("FAIL div4_mtime: got %0d required 4", o_mtime); end
    bus_txn(1'b1, 64'h0200_BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, ma);
    n_cmp++; if (o_mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL div4_max: got %h required ffffffffffffffff", o_mtime); end
    @(posedge clk); #1;
    n_cmp++; if (o_mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL div4_hold: got %h required ffffffffffffffff", o_mtime); end
    @(posedge clk); #1;
    n_cmp++; if (o_mtime !== 64'd0) begin n_fail++; $display("FAIL div4_wrap: got %h required 0", o_mtime); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_mtime_read();
    test_timer_irq();
    test_write_merge_msip();
    test_errors();
    test_resp_hold();
    test_prescaler_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
